// File: rtl/eject_reassembly_pkg.sv
// Shared flit-format definitions and slot state type for the ejection reassembly stage.
package eject_reassembly_pkg;

  localparam int unsigned WIDTH_DATA = 16;
  localparam int unsigned WIDTH_HDR  = 24;
  localparam int unsigned WIDTH_PORT = WIDTH_HDR + WIDTH_DATA;

  localparam int unsigned W_PKTID  = 6;
  localparam int unsigned W_FLITID = 2;
  localparam int unsigned W_TIME   = 8;
  localparam int unsigned W_POS    = 4;

  // Header field offsets, relative to the bit just above DATA.
  localparam int unsigned OFS_POS_Y  = 0;
  localparam int unsigned OFS_POS_X  = OFS_POS_Y + W_POS;
  localparam int unsigned OFS_TIME   = OFS_POS_X + W_POS;
  localparam int unsigned OFS_FLITID = OFS_TIME + W_TIME;
  localparam int unsigned OFS_PKTID  = OFS_FLITID + W_FLITID;

  typedef enum logic [1:0] {
    SlotIdle,
    SlotFill,
    SlotDone
  } slot_state_e;

endpackage

// File: rtl/eject_reassembly_slot.sv
// One reassembly slot: lifecycle state, arrival mask, captured header and payload lanes.
module reasm_slot
  import eject_reassembly_pkg::*;
#(
  parameter int unsigned DATA_W        = WIDTH_DATA,
  parameter int unsigned FLITS_PER_PKT = 4
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [W_PKTID-1:0]              pktid_i,
  input  logic [W_FLITID-1:0]             flitid_i,
  input  logic [W_TIME-1:0]               time_i,
  input  logic [DATA_W-1:0]               data_i,
  input  logic                            alloc_i,
  input  logic                            write_i,
  input  logic                            release_i,
  output logic                            idle_o,
  output logic                            fill_o,
  output logic                            done_o,
  output logic                            match_o,
  output logic                            hit_set_o,
  output logic [W_PKTID-1:0]              pktid_o,
  output logic [W_TIME-1:0]               time_o,
  output logic [FLITS_PER_PKT*DATA_W-1:0] data_o
);

  slot_state_e                     state_q, state_d;
  logic [W_PKTID-1:0]              pktid_q, pktid_d;
  logic [W_TIME-1:0]               time_q, time_d;
  logic [FLITS_PER_PKT-1:0]        mask_q, mask_d, lane_oh;
  logic [FLITS_PER_PKT*DATA_W-1:0] data_q, data_d;

  always_comb begin
    lane_oh = '0;
    for (int k = 0; k < FLITS_PER_PKT; k++) begin
      lane_oh[k] = (flitid_i == W_FLITID'(k));
    end
  end

  assign idle_o    = (state_q == SlotIdle);
  assign fill_o    = (state_q == SlotFill);
  assign done_o    = (state_q == SlotDone);
  assign match_o   = !idle_o && (pktid_q == pktid_i);
  assign hit_set_o = |(mask_q & lane_oh);
  assign pktid_o   = pktid_q;
  assign time_o    = time_q;
  assign data_o    = data_q;

  always_comb begin
    state_d = state_q;
    pktid_d = pktid_q;
    time_d  = time_q;
    mask_d  = mask_q;
    data_d  = data_q;
    if (release_i) begin
      state_d = SlotIdle;
      mask_d  = '0;
    end else if (alloc_i || write_i) begin
      mask_d = (alloc_i ? '0 : mask_q) | lane_oh;
      if (alloc_i) begin
        pktid_d = pktid_i;
        time_d  = time_i;
      end
      for (int k = 0; k < FLITS_PER_PKT; k++) begin
        if (lane_oh[k]) data_d[k*DATA_W +: DATA_W] = data_i;
      end
      // Completion is decided on the mask being written, so single-flit packets skip FILL.
      state_d = (&mask_d) ? SlotDone : SlotFill;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= SlotIdle;
      pktid_q <= '0;
      time_q  <= '0;
      mask_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      pktid_q <= pktid_d;
      time_q  <= time_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/eject_reassembly.sv
// Ejection-side packet reassembly: classifies each arriving flit, owns slot allocation,
// lowest-index DONE output selection, free-slot count and status pulses.
module eject_reassembly
  import eject_reassembly_pkg::*;
#(
  parameter int unsigned DATA_W        = WIDTH_DATA,
  parameter int unsigned SLOTS         = 4,
  parameter int unsigned FLITS_PER_PKT = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [WIDTH_HDR+DATA_W-1:0]     flit_in,
  input  logic                            flit_in_valid,
  output logic                            pkt_valid,
  input  logic                            pkt_ready,
  output logic [W_PKTID-1:0]              pkt_id,
  output logic [W_TIME-1:0]               pkt_time,
  output logic [FLITS_PER_PKT*DATA_W-1:0] pkt_data,
  output logic [3:0]                      slot_free_cnt,
  output logic                            drop_pulse,
  output logic                            dup_pulse,
  output logic                            err_pulse
);

  localparam int unsigned PktW = FLITS_PER_PKT * DATA_W;

  logic [WIDTH_HDR-1:0] hdr;
  logic [W_PKTID-1:0]   in_id;
  logic [W_FLITID-1:0]  in_fid;
  logic [W_TIME-1:0]    in_time;
  logic [DATA_W-1:0]    in_data;
  logic                 unused_pos;

  assign hdr        = flit_in[DATA_W +: WIDTH_HDR];
  assign in_id      = hdr[OFS_PKTID +: W_PKTID];
  assign in_fid     = hdr[OFS_FLITID +: W_FLITID];
  assign in_time    = hdr[OFS_TIME +: W_TIME];
  assign in_data    = flit_in[DATA_W-1:0];
  assign unused_pos = ^hdr[OFS_POS_Y +: 2*W_POS];

  logic [SLOTS-1:0]   s_idle, s_fill, s_done, s_match, s_hit;
  logic [SLOTS-1:0]   s_alloc, s_write, s_release, first_idle, first_done;
  logic [W_PKTID-1:0] s_id   [SLOTS];
  logic [W_TIME-1:0]  s_time [SLOTS];
  logic [PktW-1:0]    s_data [SLOTS];
  logic               flit_ok, any_match;
  logic               drop_d, dup_d, err_d, drop_q, dup_q, err_q;

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    reasm_slot #(
      .DATA_W       (DATA_W),
      .FLITS_PER_PKT(FLITS_PER_PKT)
    ) u_slot (
      .clk_i    (clk),
      .reset_i  (reset),
      .pktid_i  (in_id),
      .flitid_i (in_fid),
      .time_i   (in_time),
      .data_i   (in_data),
      .alloc_i  (s_alloc[g]),
      .write_i  (s_write[g]),
      .release_i(s_release[g]),
      .idle_o   (s_idle[g]),
      .fill_o   (s_fill[g]),
      .done_o   (s_done[g]),
      .match_o  (s_match[g]),
      .hit_set_o(s_hit[g]),
      .pktid_o  (s_id[g]),
      .time_o   (s_time[g]),
      .data_o   (s_data[g])
    );
  end

  // Isolate lowest set bit. The released slot is still DONE here, so it is never allocated
  // and a flit for its PKTID classifies as a duplicate.
  assign first_idle = s_idle & (~s_idle + SLOTS'(1));
  assign first_done = s_done & (~s_done + SLOTS'(1));

  assign flit_ok   = flit_in_valid && (32'(in_fid) < FLITS_PER_PKT);
  assign any_match = |s_match;
  assign pkt_valid = |s_done;
  assign s_release = (pkt_valid && pkt_ready) ? first_done : '0;
  assign s_write   = flit_ok ? (s_match & s_fill & ~s_hit) : '0;
  assign s_alloc   = (flit_ok && !any_match) ? first_idle : '0;

  assign err_d  = flit_in_valid && !flit_ok;
  assign dup_d  = flit_ok && any_match && !(|s_write);
  assign drop_d = flit_ok && !any_match && !(|s_idle);

  always_comb begin
    pkt_id        = '0;
    pkt_time      = '0;
    pkt_data      = '0;
    slot_free_cnt = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (first_done[i]) begin
        pkt_id   = pkt_id | s_id[i];
        pkt_time = pkt_time | s_time[i];
        pkt_data = pkt_data | s_data[i];
      end
      if (s_idle[i]) slot_free_cnt = slot_free_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= 1'b0;
      dup_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      drop_q <= drop_d;
      dup_q  <= dup_d;
      err_q  <= err_d;
    end
  end

  assign drop_pulse = drop_q;
  assign dup_pulse  = dup_q;
  assign err_pulse  = err_q;

endmodule

// File: tb/tb_eject_reassembly.sv
// Self-checking bench for eject_reassembly: directed scenarios plus random traffic against a
// packet-level reference model; a second 3-flit instance checks FLITID range errors.
module tb_eject_reassembly;

  localparam int NS = 4;
  localparam int NF = 4;
  localparam int DW = 16;

  logic          clk;
  logic          reset;
  logic [39:0]   flit_in;
  logic          flit_in_valid;
  logic          pkt_ready;
  logic          pkt_valid;
  logic [5:0]    pkt_id;
  logic [7:0]    pkt_time;
  logic [63:0]   pkt_data;
  logic [3:0]    slot_free_cnt;
  logic          drop_pulse, dup_pulse, err_pulse;

  logic          d3_valid;
  logic [5:0]    d3_id;
  logic [7:0]    d3_time;
  logic [47:0]   d3_data;
  logic [3:0]    d3_free;
  logic          d3_drop, d3_dup, d3_err;

  eject_reassembly #(.DATA_W(DW), .SLOTS(NS), .FLITS_PER_PKT(NF)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .flit_in      (flit_in),
    .flit_in_valid(flit_in_valid),
    .pkt_valid    (pkt_valid),
    .pkt_ready    (pkt_ready),
    .pkt_id       (pkt_id),
    .pkt_time     (pkt_time),
    .pkt_data     (pkt_data),
    .slot_free_cnt(slot_free_cnt),
    .drop_pulse   (drop_pulse),
    .dup_pulse    (dup_pulse),
    .err_pulse    (err_pulse)
  );

  eject_reassembly #(.DATA_W(DW), .SLOTS(2), .FLITS_PER_PKT(3)) u_dut3 (
    .clk          (clk),
    .reset        (reset),
    .flit_in      (flit_in),
    .flit_in_valid(flit_in_valid),
    .pkt_valid    (d3_valid),
    .pkt_ready    (1'b1),
    .pkt_id       (d3_id),
    .pkt_time     (d3_time),
    .pkt_data     (d3_data),
    .slot_free_cnt(d3_free),
    .drop_pulse   (d3_drop),
    .dup_pulse    (d3_dup),
    .err_pulse    (d3_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a packet is either absent, collecting lanes, or complete.
  bit          m_busy [NS];
  bit          m_done [NS];
  logic [5:0]  m_id   [NS];
  logic [7:0]  m_time [NS];
  bit          m_have [NS][NF];
  logic [15:0] m_lane [NS][NF];
  bit          exp_drop, exp_dup, exp_err3;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NS; i++) begin
      m_busy[i] = 0;
      m_done[i] = 0;
      m_id[i]   = '0;
      m_time[i] = '0;
      for (int k = 0; k < NF; k++) begin
        m_have[i][k] = 0;
        m_lane[i][k] = '0;
      end
    end
    exp_drop = 0;
    exp_dup  = 0;
    exp_err3 = 0;
  endtask

  function automatic int model_sel();
    for (int i = 0; i < NS; i++) if (m_done[i]) return i;
    return -1;
  endfunction

  task automatic check_all();
    int          sel;
    int          free;
    logic [63:0] edata;
    sel   = model_sel();
    free  = 0;
    edata = '0;
    for (int i = 0; i < NS; i++) if (!m_busy[i]) free++;
    if (sel >= 0) for (int k = 0; k < NF; k++) edata[k*DW +: DW] = m_lane[sel][k];
    check("pkt_valid", 64'(pkt_valid), 64'(sel >= 0));
    check("pkt_id", 64'(pkt_id), (sel >= 0) ? 64'(m_id[sel]) : 64'd0);
    check("pkt_time", 64'(pkt_time), (sel >= 0) ? 64'(m_time[sel]) : 64'd0);
    check("pkt_data", pkt_data, edata);
    check("free_cnt", 64'(slot_free_cnt), 64'(free));
    check("drop", 64'(drop_pulse), 64'(exp_drop));
    check("dup", 64'(dup_pulse), 64'(exp_dup));
    check("err", 64'(err_pulse), 64'd0);
    check("err3", 64'(d3_err), 64'(exp_err3));
  endtask

  task automatic cycle(input bit v, input logic [5:0] id, input logic [1:0] fid,
                       input logic [7:0] tm, input logic [15:0] d, input bit rdy);
    int  sel;
    int  hit;
    int  fr;
    bit  all;
    flit_in       = {id, fid, tm, 8'h5a, d};
    flit_in_valid = v;
    pkt_ready     = rdy;
    sel      = model_sel();
    exp_drop = 0;
    exp_dup  = 0;
    exp_err3 = v && (fid == 2'd3);
    if (v) begin
      hit = -1;
      for (int i = 0; i < NS; i++) if (m_busy[i] && m_id[i] == id) hit = i;
      if (hit >= 0) begin
        if (m_done[hit] || m_have[hit][fid]) exp_dup = 1;
        else begin
          m_have[hit][fid] = 1;
          m_lane[hit][fid] = d;
        end
      end else begin
        fr = -1;
        for (int i = NS - 1; i >= 0; i--) if (!m_busy[i]) fr = i;
        if (fr < 0) exp_drop = 1;
        else begin
          m_busy[fr] = 1;
          m_id[fr]   = id;
          m_time[fr] = tm;
          for (int k = 0; k < NF; k++) m_have[fr][k] = 0;
          m_have[fr][fid] = 1;
          m_lane[fr][fid] = d;
        end
      end
    end
    for (int i = 0; i < NS; i++) begin
      all = 1;
      for (int k = 0; k < NF; k++) if (!m_have[i][k]) all = 0;
      if (m_busy[i] && all) m_done[i] = 1;
    end
    if (sel >= 0 && rdy) begin
      m_busy[sel] = 0;
      m_done[sel] = 0;
      for (int k = 0; k < NF; k++) m_have[sel][k] = 0;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(0, 6'd0, 2'd0, 8'd0, 16'd0, rdy);
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    flit_in_valid = 1'b0;
    pkt_ready     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    check_all();
    reset = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    flit_in = '0;
    model_clear();
    do_reset();

    // In-order fill with immediate acceptance.
    cycle(1, 6'd1, 2'd0, 8'h11, 16'hAAAA, 1);
    cycle(1, 6'd1, 2'd1, 8'h12, 16'hBBBB, 1);
    cycle(1, 6'd1, 2'd2, 8'h13, 16'hCCCC, 1);
    cycle(1, 6'd1, 2'd3, 8'h14, 16'hDDDD, 1);
    idle(3, 1);

    // Out-of-order interleave of two packets.
    cycle(1, 6'd2, 2'd3, 8'h20, 16'h2003, 1);
    cycle(1, 6'd2, 2'd1, 8'h21, 16'h2001, 1);
    for (int k = 0; k < 4; k++) cycle(1, 6'd3, 2'(k), 8'(8'h30 + k), 16'(16'h3000 + k), 1);
    cycle(1, 6'd2, 2'd0, 8'h22, 16'h2000, 1);
    cycle(1, 6'd2, 2'd2, 8'h23, 16'h2002, 1);
    idle(3, 1);

    // Duplicate mid-fill must not overwrite the stored lane.
    cycle(1, 6'd5, 2'd2, 8'h50, 16'h5502, 1);
    cycle(1, 6'd5, 2'd2, 8'h51, 16'hDEAD, 1);
    cycle(1, 6'd5, 2'd0, 8'h52, 16'h5500, 1);
    cycle(1, 6'd5, 2'd1, 8'h53, 16'h5501, 1);
    cycle(1, 6'd5, 2'd3, 8'h54, 16'h5503, 1);
    cycle(1, 6'd5, 2'd1, 8'h55, 16'hBEEF, 1);
    idle(2, 1);

    // Overflow, backpressure hold, then the release/arrival race.
    for (int p = 0; p < 5; p++) cycle(1, 6'(10 + p), 2'd0, 8'(8'h60 + p), 16'(16'h6000 + p), 0);
    for (int k = 1; k < 4; k++) begin
      cycle(1, 6'd11, 2'(k), 8'h70, 16'(16'hB100 + k), 0);
      cycle(1, 6'd10, 2'(k), 8'h71, 16'(16'hA100 + k), 0);
    end
    idle(5, 0);
    cycle(1, 6'd20, 2'd0, 8'h80, 16'h2020, 1);
    cycle(1, 6'd20, 2'd0, 8'h81, 16'h2021, 0);
    cycle(1, 6'd11, 2'd0, 8'h82, 16'h2022, 1);
    idle(3, 1);

    // Reset in the middle of a packet, then a clean resend.
    do_reset();
    cycle(1, 6'd30, 2'd0, 8'h90, 16'h3000, 1);
    cycle(1, 6'd30, 2'd1, 8'h91, 16'h3001, 1);
    do_reset();
    for (int k = 0; k < 4; k++) cycle(1, 6'd30, 2'(k), 8'(8'h92 + k), 16'(16'h3100 + k), 1);
    idle(2, 1);

    // Random traffic over a small PKTID pool to exercise drops, dups and reordering.
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(0, 9) < 7), 6'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            8'($urandom), 16'($urandom), ($urandom_range(0, 1) == 1));
    end
    idle(10, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
